pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline-stage register for the five-stage CPU datapath, replacing the per-field stall/flush flop banks between stages with one valid/ready stage. It carries a control bundle and a data bundle of configurable widths, absorbs downstream back-pressure with an optional two-entry skid buffer, and supports flush-to-bubble. It also gates control fields to zero on bubbles and keeps a saturating back-pressure counter for performance debug.

## Interface
- DATA_W, 128, data bundle width (PC+4, ALU result, memory data, instruction, ...)
- CTRL_W, 8, control bundle width (RegWrite, RegDst, MemtoReg, ...); must be ≥1
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- STALL_W, 16, width of the back-pressure counter

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  kills all held entries and the entry presented this cycle
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control bundle; forced to 0 whenever out_valid=0
- out_data  out  DATA_W  data bundle; holds last loaded value when out_valid=0
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)
- stall_cnt  out  STALL_W  cycles with out_valid & ~out_ready, saturating

## Operation
- Accept: in_valid & in_ready. Deliver: out_valid & out_ready.
- Entries: main M drives the outputs; skid S exists only when SKID=1. Strict FIFO order, never reordered or duplicated.
- SKID=1:
  - in_ready = ~S.valid (registered; no combinational path from out_ready).
  - Accept with M empty, or M delivering this cycle, loads M.
  - Accept with M held (no deliver) loads S.
  - Deliver with S valid moves S to M. A simultaneous accept loads S.
- SKID=0:
  - in_ready = ~M.valid | out_ready.
  - Accept loads M. Deliver without accept empties M.
- Flush has priority over everything else:
  - Next cycle M.valid=S.valid=0; ctrl registers are cleared to 0.
  - An entry accepted in the flush cycle is discarded.
  - A delivery in the flush cycle still counts as completed downstream.
  - in_ready is computed as normal during flush.
- out_ctrl = M.valid ? M.ctrl : 0. The bubble therefore never asserts a write-enable.
- occupancy = M.valid + S.valid.
- stall_cnt increments by 1 each cycle with out_valid & ~out_ready and holds at 2^STALL_W−1. It is cleared only by reset; flush does not clear it.

## Timing
- Reset (synchronous), values after the edge with reset=1:
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, S cleared.
  - in_ready=0 while reset is high; in_ready=1 on the first cycle after reset drops.
- Reset mid-operation discards all held entries, with no delivery on that edge.
- Latency: 1 cycle. An entry accepted at edge N is visible on the outputs after edge N.
- Throughput: 1 entry/cycle sustained with out_ready=1, in both modes.
- SKID=1:
  - After out_ready drops, at most 1 further entry is accepted (into S). in_ready falls the cycle after S fills.
  - in_ready rises the cycle after S drains.
- Reset beats flush; flush beats accept/move.

## Test plan
- Streaming, SKID=1: after reset, present 8 entries ctrl=k, data=0x100+k on consecutive cycles with out_ready=1. Expect out_valid from cycle 1, data 0x100..0x107 in order, one per cycle, occupancy=1, stall_cnt=0.
- Back-pressure, SKID=1: M holds A, then out_ready=0 for 4 cycles while in_valid=1 with B, C. Expect B accepted into S, occupancy=2, in_ready=0 next cycle, C held upstream, out_data=A stable, stall_cnt=4. Then out_ready=1 delivers A, B, C in order with no gap.
- Flush: occupancy=2, assert flush with in_valid=1 (entry D). Expect next cycle out_valid=0, out_ctrl=0, occupancy=0, D never appears, stall_cnt unchanged.
- SKID=0: out_ready=0 with M full gives in_ready=0 combinationally. Set out_ready=1 and in_valid=1 in the same cycle: expect replace-in-place, occupancy stays 1, and no entry is lost.
- Saturation: STALL_W=4, hold out_valid=1 and out_ready=0 for 20 cycles. Expect stall_cnt to reach 15 and hold there; reset returns it to 0.
- Reset mid-stream: assert reset with occupancy=2 and in_valid=1. Expect all outputs at reset values next cycle, and no held or incoming entry delivered afterwards.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register carrying a control and a data bundle,
// with an optional two-entry skid buffer, flush-to-bubble and a saturating stall counter.
module pipe_stage_reg #(
    parameter int DATA_W  = 128,
    parameter int CTRL_W  = 8,
    parameter int SKID    = 1,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data,
    output logic [1:0]         occupancy,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam bit                 HAS_SKID  = (SKID != 0);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;
    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    logic               m_valid_reg, m_valid_next;
    logic [CTRL_W-1:0]  m_ctrl_reg,  m_ctrl_next;
    logic [DATA_W-1:0]  m_data_reg,  m_data_next;
    logic               s_valid_reg, s_valid_next;
    logic [CTRL_W-1:0]  s_ctrl_reg,  s_ctrl_next;
    logic [DATA_W-1:0]  s_data_reg,  s_data_next;
    logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;

    logic accept;
    logic deliver;

    // With the skid buffer, ready depends only on held state so out_ready never
    // reaches in_ready; without it, a delivering entry frees the slot in the same cycle.
    generate
        if (HAS_SKID) begin : g_ready_skid
            assign in_ready = ~reset & ~s_valid_reg;
        end else begin : g_ready_direct
            assign in_ready = ~reset & (~m_valid_reg | out_ready);
        end
    endgenerate

    assign accept  = in_valid & in_ready;
    assign deliver = m_valid_reg & out_ready;

    always_comb begin
        m_valid_next = m_valid_reg;
        m_ctrl_next  = m_ctrl_reg;
        m_data_next  = m_data_reg;
        s_valid_next = s_valid_reg;
        s_ctrl_next  = s_ctrl_reg;
        s_data_next  = s_data_reg;

        if (flush) begin
            // Data is left in place; only valid and control are killed.
            m_valid_next = 1'b0;
            s_valid_next = 1'b0;
            m_ctrl_next  = '0;
            s_ctrl_next  = '0;
        end else if (HAS_SKID && deliver && s_valid_reg) begin
            m_valid_next = 1'b1;
            m_ctrl_next  = s_ctrl_reg;
            m_data_next  = s_data_reg;
            s_valid_next = accept;
            if (accept) begin
                s_ctrl_next = in_ctrl;
                s_data_next = in_data;
            end
        end else if (!m_valid_reg || deliver) begin
            m_valid_next = accept;
            if (accept) begin
                m_ctrl_next = in_ctrl;
                m_data_next = in_data;
            end
        end else if (HAS_SKID && accept) begin
            s_valid_next = 1'b1;
            s_ctrl_next  = in_ctrl;
            s_data_next  = in_data;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (m_valid_reg && !out_ready && (stall_cnt_reg != STALL_MAX)) begin
            stall_cnt_next = stall_cnt_reg + STALL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_reg   <= 1'b0;
            m_ctrl_reg    <= '0;
            m_data_reg    <= '0;
            s_valid_reg   <= 1'b0;
            s_ctrl_reg    <= '0;
            s_data_reg    <= '0;
            stall_cnt_reg <= '0;
        end else begin
            m_valid_reg   <= m_valid_next;
            m_ctrl_reg    <= m_ctrl_next;
            m_data_reg    <= m_data_next;
            s_valid_reg   <= s_valid_next;
            s_ctrl_reg    <= s_ctrl_next;
            s_data_reg    <= s_data_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // A bubble must never present a stale write-enable downstream.
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
            assign out_ctrl[gi] = m_valid_reg & m_ctrl_reg[gi];
        end
    endgenerate

    assign out_valid = m_valid_reg;
    assign out_data  = m_data_reg;
    assign occupancy = {1'b0, m_valid_reg} + {1'b0, s_valid_reg};
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (skid, no skid, 4-bit stall counter)
// checked against a FIFO scoreboard plus an independent ready/stall model.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset     [3];
    logic         flush     [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [7:0]   in_ctrl   [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [7:0]   out_ctrl  [3];
    logic [127:0] out_data  [3];
    logic [1:0]   occupancy [3];
    logic [15:0]  stall_a;
    logic [15:0]  stall_b;
    logic [3:0]   stall_c;

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(8), .SKID(1), .STALL_W(16)) u_skid (
        .clk(clk), .reset(reset[0]), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]), .out_data(out_data[0]),
        .occupancy(occupancy[0]), .stall_cnt(stall_a)
    );

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(8), .SKID(0), .STALL_W(16)) u_noskid (
        .clk(clk), .reset(reset[1]), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]), .out_data(out_data[1]),
        .occupancy(occupancy[1]), .stall_cnt(stall_b)
    );

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(8), .SKID(1), .STALL_W(4)) u_sat (
        .clk(clk), .reset(reset[2]), .flush(flush[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_ctrl(in_ctrl[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_ctrl(out_ctrl[2]), .out_data(out_data[2]),
        .occupancy(occupancy[2]), .stall_cnt(stall_c)
    );

    int checks = 0;
    int errors = 0;
    int ndel   = 0;
    int exp_stall = 0;
    logic [135:0] sb [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] get_stall(input int d);
        if (d == 0) return stall_a;
        if (d == 1) return stall_b;
        return {12'd0, stall_c};
    endfunction

    // One clock of stimulus on instance d; returns whether the entry was accepted.
    task automatic cycle(input int d, input bit v, input logic [7:0] c, input logic [127:0] dat,
                         input bit ordy, input bit fl, input bit rst, output bit acc);
        bit del;
        bit exp_rdy;
        logic [135:0] e;
        int smax;
        in_valid[d] = v; in_ctrl[d] = c; in_data[d] = dat;
        out_ready[d] = ordy; flush[d] = fl; reset[d] = rst;
        @(negedge clk);
        smax = (d == 2) ? 15 : 65535;
        if (d == 1) exp_rdy = !rst && (sb.size() == 0 || ordy);
        else        exp_rdy = !rst && (sb.size() < 2);
        check("in_ready_pre", 128'(in_ready[d]), 128'(exp_rdy));
        acc = in_valid[d] & in_ready[d];
        del = out_valid[d] & out_ready[d];
        if (rst) begin
            sb.delete();
            exp_stall = 0;
        end else begin
            if (out_valid[d] && !ordy && exp_stall < smax) exp_stall++;
            if (del) begin
                if (sb.size() == 0) begin
                    check("unexpected_delivery", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    ndel++;
                    check("out_data", out_data[d], e[127:0]);
                    check("out_ctrl", 128'(out_ctrl[d]), 128'(e[135:128]));
                    $display("dut%0d deliver ctrl=%0h data=%0h", d, out_ctrl[d], out_data[d]);
                end
            end
            if (fl) sb.delete();
            else if (acc) sb.push_back({c, dat});
        end
        @(posedge clk);
        #1;
        check("occupancy", 128'(occupancy[d]), 128'(sb.size()));
        check("out_valid", 128'(out_valid[d]), 128'(sb.size() != 0));
        if (sb.size() == 0) check("bubble_ctrl", 128'(out_ctrl[d]), 128'(0));
        check("stall_cnt", 128'(get_stall(d)), 128'(exp_stall));
    endtask

    initial begin
        bit a;
        logic [15:0] st;
        int n0;
        for (int i = 0; i < 3; i++) begin
            reset[i] = 1'b1; flush[i] = 1'b0; in_valid[i] = 1'b0;
            in_ctrl[i] = '0; in_data[i] = '0; out_ready[i] = 1'b1;
        end

        // Streaming with skid buffer
        cycle(0, 0, 8'h0, 128'h0, 1, 0, 1, a);
        check("reset_out_data", out_data[0], 128'h0);
        for (int k = 0; k < 8; k++) begin
            cycle(0, 1, 8'(k), 128'(32'h100 + k), 1, 0, 0, a);
            check("stream_accept", 128'(a), 128'(1));
        end
        cycle(0, 0, 8'h0, 128'h0, 1, 0, 0, a);
        check("stream_count", 128'(ndel), 128'(8));

        // Back-pressure: A held, B into skid, C held upstream
        cycle(0, 1, 8'hA1, 128'hAAAA, 1, 0, 0, a);
        cycle(0, 1, 8'hB2, 128'hBBBB, 0, 0, 0, a);
        check("bp_b_accepted", 128'(a), 128'(1));
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 8'hC3, 128'hCCCC, 0, 0, 0, a);
            check("bp_c_held", 128'(a), 128'(0));
            check("bp_a_stable", out_data[0], 128'hAAAA);
        end
        check("bp_stall4", 128'(stall_a), 128'(4));
        n0 = ndel;
        cycle(0, 1, 8'hC3, 128'hCCCC, 1, 0, 0, a);
        cycle(0, 1, 8'hC3, 128'hCCCC, 1, 0, 0, a);
        check("bp_c_accepted", 128'(a), 128'(1));
        cycle(0, 0, 8'h0, 128'h0, 1, 0, 0, a);
        check("bp_no_gap", 128'(ndel - n0), 128'(3));

        // Flush with both entries held and D presented
        cycle(0, 1, 8'h11, 128'h1111, 0, 0, 0, a);
        cycle(0, 1, 8'h22, 128'h2222, 0, 0, 0, a);
        st = stall_a;
        cycle(0, 1, 8'hDD, 128'hDDDD, 1, 1, 0, a);
        check("flush_stall_kept", 128'(stall_a), 128'(st));
        for (int k = 0; k < 3; k++) cycle(0, 0, 8'h0, 128'h0, 1, 0, 0, a);
        cycle(0, 1, 8'hEE, 128'hEEEE, 1, 0, 0, a);
        cycle(0, 0, 8'h0, 128'h0, 1, 0, 0, a);

        // Reset mid-stream
        cycle(0, 1, 8'h33, 128'h3333, 0, 0, 0, a);
        cycle(0, 1, 8'h44, 128'h4444, 0, 0, 0, a);
        cycle(0, 1, 8'h55, 128'h5555, 1, 0, 1, a);
        check("rst_mid_data", out_data[0], 128'h0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 8'h0, 128'h0, 1, 0, 0, a);

        // No skid buffer: replace in place
        cycle(1, 0, 8'h0, 128'h0, 1, 0, 1, a);
        cycle(1, 1, 8'h61, 128'h6161, 1, 0, 0, a);
        cycle(1, 1, 8'h62, 128'h6262, 0, 0, 0, a);
        check("ns_blocked", 128'(a), 128'(0));
        cycle(1, 1, 8'h62, 128'h6262, 1, 0, 0, a);
        check("ns_replace", 128'(a), 128'(1));
        cycle(1, 1, 8'h63, 128'h6363, 1, 0, 0, a);
        cycle(1, 0, 8'h0, 128'h0, 1, 0, 0, a);

        // Stall counter saturation at 15
        cycle(2, 0, 8'h0, 128'h0, 1, 0, 1, a);
        cycle(2, 1, 8'h71, 128'h7171, 0, 0, 0, a);
        for (int k = 0; k < 20; k++) cycle(2, 0, 8'h0, 128'h0, 0, 0, 0, a);
        check("sat_15", 128'(stall_c), 128'(15));
        cycle(2, 0, 8'h0, 128'h0, 0, 0, 1, a);
        check("sat_reset", 128'(stall_c), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
